// File: rtl/regfile_wb_arb_pkg.sv
// regfile_wb_arb_pkg: shared register-file widths and address type for the write-back arbiter
package regfile_wb_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam int DEF_XLEN = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_wb_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (req, ptr -> one-hot gnt, gnt_idx, gnt_any), first req at or above ptr with wrap
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);
  localparam int W = $clog2(N);
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt_idx = W'((int'(ptr) + k) % N);
        gnt_any = 1'b1;
      end
  end
  assign gnt = {N{gnt_any}} & (N'(1) << gnt_idx);
endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: round-robin write-back arbiter onto the regfile write port (req_* in, rf_* out) with optional RAW scoreboard (iss_*/chk_* in, rs*_busy out) enabled by WB_SCOREBOARD_EN; rst is async active-low
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = DEF_XLEN
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_valid,
  output logic [NREQ-1:0]                      req_ready,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]      req_addr,
  input  logic [NREQ-1:0][XLEN-1:0]            req_data,
  output logic                                 rf_wen,
  output logic [REG_ADDR_W-1:0]                rf_waddr,
  output logic [XLEN-1:0]                      rf_wdata,
  input  logic                                 iss_valid,
  input  logic [REG_ADDR_W-1:0]                iss_rd,
  input  logic [REG_ADDR_W-1:0]                chk_rs1,
  input  logic [REG_ADDR_W-1:0]                chk_rs2,
  output logic                                 rs1_busy,
  output logic                                 rs2_busy
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] rr_ptr, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic gnt_any;
  reg_addr_t g_addr;
  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid & {NREQ{rst}}),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );
  assign req_ready = gnt;
  assign g_addr = req_addr[gnt_idx];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_ptr <= '0;
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= gnt_any && g_addr != '0;
      if (gnt_any) begin
        rr_ptr <= gnt_idx == PW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
        rf_waddr <= g_addr;
        rf_wdata <= req_data[gnt_idx];
      end
    end
`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy, busy_set, busy_clr;
  assign busy_set = iss_valid ? NUM_REGS'(1) << iss_rd : '0;
  assign busy_clr = gnt_any ? NUM_REGS'(1) << g_addr : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy <= '0;
    else busy <= ((busy & ~busy_clr) | busy_set) & ~NUM_REGS'(1);
  assign rs1_busy = busy[chk_rs1];
  assign rs2_busy = busy[chk_rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, chk_rs1, chk_rs2};
  assign rs1_busy = 1'b0;
  assign rs2_busy = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: randomized and directed checks of regfile_wb_arb against a behavioural model
module tb_regfile_wb_arb;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ-1:0][4:0] req_addr;
  logic [NREQ-1:0][XLEN-1:0] req_data;
  logic rf_wen;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic iss_valid;
  logic [4:0] iss_rd, chk_rs1, chk_rs2;
  logic rs1_busy, rs2_busy;
  int n_pass = 0;
  int n_total = 0;
  int m_ptr = 0;
  bit m_wen = 1'b0;
  bit [4:0] m_waddr = '0;
  bit [31:0] m_wdata = '0;
  bit [31:0] m_busy = '0;

  regfile_wb_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    if (!rst) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = model_grant();
    return g < 0 ? '0 : NREQ'(1) << g;
  endfunction

  function automatic bit exp_busy(input logic [4:0] r);
    return SB && m_busy[r];
  endfunction

  task automatic model_edge();
    int g;
    g = model_grant();
    if (!rst) begin
      m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
    end else begin
      m_wen = 0;
      if (g >= 0) begin
        m_wen = req_addr[g] != 0;
        m_waddr = req_addr[g];
        m_wdata = req_data[g];
        m_ptr = (g + 1) % NREQ;
        if (req_addr[g] != 0) m_busy[req_addr[g]] = 0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin req_addr[i] = 5'(i + 7); req_data[i] = 32'h1000 + i; end
    iss_valid = 1; iss_rd = 3; chk_rs1 = 3; chk_rs2 = 7;
    @(posedge clk); @(posedge clk); #4;
    n_total++; if (req_ready !== '0) $display("FAIL reset_ready got %b want 000", req_ready); else n_pass++;
    n_total++; if (rf_wen !== 1'b0) $display("FAIL reset_wen got %b want 0", rf_wen); else n_pass++;
    n_total++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr got %0d want 0", rf_waddr); else n_pass++;
    n_total++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata got %h want 0", rf_wdata); else n_pass++;
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", rs1_busy); else n_pass++;
    req_valid = '0; iss_valid = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_round_robin();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin req_addr[i] = 5'(i + 1); req_data[i] = 32'hcafe0000 + i; end
    for (int c = 0; c < 6; c++) begin
      #4;
      n_total++;
      if (req_ready !== NREQ'(1) << (c % 3)) $display("FAIL rr_grant cycle %0d got %b want %b", c, req_ready, NREQ'(1) << (c % 3)); else n_pass++;
      tick();
      n_total++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'(c % 3 + 1)) $display("FAIL rr_write cycle %0d got wen %b addr %0d want 1 %0d", c, rf_wen, rf_waddr, c % 3 + 1); else n_pass++;
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    req_valid = 3'b011;
    req_addr[0] = 1; req_data[0] = 32'hdeadbeef;
    req_addr[1] = 1; req_data[1] = 32'h8badf00d;
    #4;
    n_total++; if (req_ready !== 3'b001) $display("FAIL b2b_first got %b want 001", req_ready); else n_pass++;
    tick();
    n_total++; if (rf_wen !== 1'b1 || rf_wdata !== 32'hdeadbeef) $display("FAIL b2b_w1 got %b %h want 1 deadbeef", rf_wen, rf_wdata); else n_pass++;
    req_valid = 3'b010;
    #4;
    n_total++; if (req_ready !== 3'b010) $display("FAIL b2b_second got %b want 010", req_ready); else n_pass++;
    tick();
    n_total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h8badf00d) $display("FAIL b2b_w2 got %b %0d %h want 1 1 8badf00d", rf_wen, rf_waddr, rf_wdata); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_single_write();
    req_valid = 3'b010; req_addr[1] = 5; req_data[1] = 32'hdeadbeef;
    #4;
    n_total++; if (req_ready !== 3'b010) $display("FAIL single_ready got %b want 010", req_ready); else n_pass++;
    tick();
    n_total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hdeadbeef) $display("FAIL single_write got %b %0d %h want 1 5 deadbeef", rf_wen, rf_waddr, rf_wdata); else n_pass++;
    req_valid = '0;
    #4;
    tick();
    n_total++; if (rf_wen !== 1'b0 || rf_wdata !== 32'hdeadbeef) $display("FAIL single_idle got %b %h want 0 deadbeef", rf_wen, rf_wdata); else n_pass++;
  endtask

  task automatic test_x0_drop();
    req_valid = 3'b001; req_addr[0] = 0; req_data[0] = 32'hb105f00d;
    #4;
    n_total++; if (req_ready !== 3'b001) $display("FAIL x0_ready got %b want 001", req_ready); else n_pass++;
    tick();
    n_total++; if (rf_wen !== 1'b0 || rf_wdata !== 32'hb105f00d) $display("FAIL x0_write got %b %h want 0 b105f00d", rf_wen, rf_wdata); else n_pass++;
    req_valid = '1;
    #1;
    n_total++; if (req_ready !== 3'b010) $display("FAIL x0_ptr got %b want 010", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_scoreboard();
    req_valid = '0; iss_valid = 1; iss_rd = 3; chk_rs1 = 3; chk_rs2 = 4;
    #4; tick();
    n_total++; if (rs1_busy !== SB || rs2_busy !== 1'b0) $display("FAIL sb_set got %b %b want %b 0", rs1_busy, rs2_busy, SB); else n_pass++;
    iss_valid = 0; req_valid = 3'b100; req_addr[2] = 3; req_data[2] = 32'h33;
    #4; tick();
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL sb_clear got %b want 0", rs1_busy); else n_pass++;
    req_valid = '0; iss_valid = 1;
    #4; tick();
    req_valid = 3'b100;
    #4; tick();
    n_total++; if (rs1_busy !== SB) $display("FAIL sb_set_wins got %b want %b", rs1_busy, SB); else n_pass++;
    iss_valid = 0;
    #4; tick();
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL sb_final got %b want 0", rs1_busy); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin req_addr[i] = 5'($urandom_range(0, 7)); req_data[i] = $urandom; end
      iss_valid = 1'($urandom); iss_rd = 5'($urandom_range(0, 7));
      chk_rs1 = 5'($urandom_range(0, 7)); chk_rs2 = 5'($urandom_range(0, 7));
      #4;
      n_total++; if (req_ready !== exp_ready()) $display("FAIL rnd_ready cycle %0d got %b want %b", c, req_ready, exp_ready()); else n_pass++;
      tick();
      n_total++;
      if (rf_wen !== m_wen || rf_waddr !== m_waddr || rf_wdata !== m_wdata)
        $display("FAIL rnd_write cycle %0d got %b %0d %h want %b %0d %h", c, rf_wen, rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata);
      else n_pass++;
      n_total++;
      if (rs1_busy !== exp_busy(chk_rs1) || rs2_busy !== exp_busy(chk_rs2))
        $display("FAIL rnd_busy cycle %0d got %b %b want %b %b", c, rs1_busy, rs2_busy, exp_busy(chk_rs1), exp_busy(chk_rs2));
      else n_pass++;
    end
    req_valid = '0; iss_valid = 0;
  endtask

  task automatic test_reset_mid();
    #4; tick();
    req_valid = 3'b001; req_addr[0] = 9; req_data[0] = 32'h99;
    iss_valid = 1; iss_rd = 9; chk_rs1 = 9;
    #4; tick();
    n_total++; if (rf_wen !== 1'b1 || rs1_busy !== SB) $display("FAIL mid_pre got %b %b want 1 %b", rf_wen, rs1_busy, SB); else n_pass++;
    req_valid = '1; iss_valid = 0;
    #2; rst = 0; #1;
    n_total++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) $display("FAIL mid_reset_out got %b %0d %h want 0 0 0", rf_wen, rf_waddr, rf_wdata); else n_pass++;
    n_total++; if (rs1_busy !== 1'b0 || req_ready !== '0) $display("FAIL mid_reset_state got %b %b want 0 000", rs1_busy, req_ready); else n_pass++;
    tick();
    rst = 1;
    #1;
    n_total++; if (req_ready !== 3'b001) $display("FAIL mid_ptr got %b want 001", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0; req_addr = '0; req_data = '0;
    iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_single_write();
    test_x0_drop();
    test_scoreboard();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
